// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with a clock-enable pixel divider.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   p_tick       pixel strobe, high one clk per pixel period (0 in reset)
//   pixel_x      horizontal position, 0..H_TOTAL-1
//   pixel_y      vertical position, 0..V_TOTAL-1
//   video_on     high inside the visible area, aligned with pixel_x/pixel_y
//   hsync        horizontal sync, asserted level = SYNC_POL
//   vsync        vertical sync, asserted level = SYNC_POL
//   line_start   high for the p_tick cycle where pixel_x == 0
//   frame_start  high for the p_tick cycle where pixel_x == 0 and pixel_y == 0
module vga_sync_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   CLK_DIV   = 2,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Geometry that cannot be represented by the 10-bit counters is rejected
  // while elaborating rather than producing a silently wrong raster.
  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("vga_sync_gen: H_TOTAL must not exceed 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("vga_sync_gen: V_TOTAL must not exceed 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_clk_div_err
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VISIBLE  = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VISIBLE  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [3:0] div_cnt_r;
  logic [9:0] x_r;
  logic [9:0] y_r;
  logic       video_on_r;
  logic       hsync_r;
  logic       vsync_r;

  logic       tick_s;
  logic [3:0] div_nxt_s;
  logic [9:0] x_nxt_s;
  logic [9:0] y_nxt_s;
  logic       video_nxt_s;
  logic       hsync_nxt_s;
  logic       vsync_nxt_s;

  // With CLK_DIV == 1 the divider sits at 0 == DIV_LAST, so the tick is
  // permanently high outside reset.
  assign tick_s = ~reset & (div_cnt_r == DIV_LAST);

  // Next-state counters and the decode of that next state, so the
  // registered decodes line up with pixel_x/pixel_y on the same clk.
  always_comb begin
    div_nxt_s   = div_cnt_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    video_nxt_s = 1'b0;
    hsync_nxt_s = ~SYNC_POL;
    vsync_nxt_s = ~SYNC_POL;

    if (reset) begin
      div_nxt_s = 4'd0;
      x_nxt_s   = 10'd0;
      y_nxt_s   = 10'd0;
    end else if (tick_s) begin
      div_nxt_s = 4'd0;
      if (x_r == X_LAST) begin
        x_nxt_s = 10'd0;
        if (y_r == Y_LAST) begin
          y_nxt_s = 10'd0;
        end else begin
          y_nxt_s = y_r + 10'd1;
        end
      end else begin
        x_nxt_s = x_r + 10'd1;
        y_nxt_s = y_r;
      end
    end else begin
      div_nxt_s = div_cnt_r + 4'd1;
    end

    // Reset drives deasserted decodes so a mid-frame reset never holds a
    // partial sync pulse.
    if (reset) begin
      video_nxt_s = 1'b0;
      hsync_nxt_s = ~SYNC_POL;
      vsync_nxt_s = ~SYNC_POL;
    end else begin
      video_nxt_s = (x_nxt_s < X_VISIBLE) && (y_nxt_s < Y_VISIBLE);
      if ((x_nxt_s >= HS_FIRST) && (x_nxt_s <= HS_LAST)) begin
        hsync_nxt_s = SYNC_POL;
      end else begin
        hsync_nxt_s = ~SYNC_POL;
      end
      if ((y_nxt_s >= VS_FIRST) && (y_nxt_s <= VS_LAST)) begin
        vsync_nxt_s = SYNC_POL;
      end else begin
        vsync_nxt_s = ~SYNC_POL;
      end
    end
  end

  // Divider, raster counters and decode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r  <= 4'd0;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      video_on_r <= 1'b0;
      hsync_r    <= ~SYNC_POL;
      vsync_r    <= ~SYNC_POL;
    end else begin
      div_cnt_r  <= div_nxt_s;
      x_r        <= x_nxt_s;
      y_r        <= y_nxt_s;
      video_on_r <= video_nxt_s;
      hsync_r    <= hsync_nxt_s;
      vsync_r    <= vsync_nxt_s;
    end
  end

  assign p_tick      = tick_s;
  assign pixel_x     = x_r;
  assign pixel_y     = y_r;
  assign video_on    = video_on_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = tick_s & (x_r == 10'd0);
  assign frame_start = tick_s & (x_r == 10'd0) & (y_r == 10'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a reduced raster so whole frames fit
// in a short run. Geometry: H 8+2+3+3 = 16 (hsync x=10..12),
// V 4+1+2+2 = 9 (vsync y=5..6).
// dut  : CLK_DIV=2, SYNC_POL=0 -> 32 clks/line, 288 clks/frame
// dut1 : CLK_DIV=1, SYNC_POL=1 -> 16 clks/line, 144 clks/frame
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       p_tick, video_on, hsync, vsync, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       p_tick1, video_on1, hsync1, vsync1, line_start1, frame_start1;
  logic [9:0] pixel_x1, pixel_y1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .p_tick(p_tick1),
    .pixel_x(pixel_x1), .pixel_y(pixel_y1), .video_on(video_on1),
    .hsync(hsync1), .vsync(vsync1),
    .line_start(line_start1), .frame_start(frame_start1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, 32'(pixel_x), 32'd0);
    check({tag, "_y"}, 32'(pixel_y), 32'd0);
    check({tag, "_video_on"}, 32'(video_on), 32'd0);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_p_tick"}, 32'(p_tick), 32'd0);
    check({tag, "_line_start"}, 32'(line_start), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_hsync1"}, 32'(hsync1), 32'd0);
    check({tag, "_vsync1"}, 32'(vsync1), 32'd0);
    check({tag, "_p_tick1"}, 32'(p_tick1), 32'd0);
  endtask

  initial begin
    int n_tick, n_ls, n_fs, n_hs, n_vs, n_vid, n_xchg, max_x, max_y;
    int n_tick1, n_ls1, n_fs1, n_hs1, n_vs1, n_vid1, n_xchg1;
    int dec_bad, dec_bad1, gap_bad, gap_bad1, wrap_bad, wrap_seen, fs_bad;
    int last_ls, last_fs, last_ls1, last_fs1;
    logic [9:0] px, py, px1;
    logic exp_v, exp_h, exp_s;
    bit found;

    // Reset from power-up for 3 clks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");

    // Release and look at the combinational strobes before the first edge.
    reset = 1'b0;
    #1;
    check("rel0_p_tick", 32'(p_tick), 32'd0);
    check("rel0_p_tick1", 32'(p_tick1), 32'd1);
    check("rel0_frame_start1", 32'(frame_start1), 32'd1);
    check("rel0_video_on", 32'(video_on), 32'd0);

    // First edge after release: video_on loads, frame_start appears.
    @(negedge clk);
    check("rel1_video_on", 32'(video_on), 32'd1);
    check("rel1_p_tick", 32'(p_tick), 32'd1);
    check("rel1_frame_start", 32'(frame_start), 32'd1);
    check("rel1_line_start", 32'(line_start), 32'd1);
    check("rel1_x", 32'(pixel_x), 32'd0);
    check("rel1_x1", 32'(pixel_x1), 32'd1);

    @(negedge clk);
    check("rel2_x", 32'(pixel_x), 32'd1);
    check("rel2_p_tick", 32'(p_tick), 32'd0);
    check("rel2_frame_start", 32'(frame_start), 32'd0);

    // Statistics over exactly 576 clks = 2 frames of dut, 4 frames of dut1.
    n_tick = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_vid = 0; n_xchg = 0;
    n_tick1 = 0; n_ls1 = 0; n_fs1 = 0; n_hs1 = 0; n_vs1 = 0; n_vid1 = 0; n_xchg1 = 0;
    max_x = 0; max_y = 0;
    dec_bad = 0; dec_bad1 = 0; gap_bad = 0; gap_bad1 = 0;
    wrap_bad = 0; wrap_seen = 0; fs_bad = 0;
    last_ls = -1; last_fs = -1; last_ls1 = -1; last_fs1 = -1;
    px = pixel_x; py = pixel_y; px1 = pixel_x1;
    for (int i = 0; i < 576; i++) begin
      @(negedge clk);
      if (p_tick) n_tick++;
      if (!hsync) n_hs++;
      if (!vsync) n_vs++;
      if (video_on) n_vid++;
      if (pixel_x != px) n_xchg++;
      if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
      if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
      if ((px == 10'd15) && (py == 10'd8) && (pixel_x != px)) begin
        wrap_seen++;
        if ((pixel_x != 10'd0) || (pixel_y != 10'd0)) wrap_bad++;
      end
      if (line_start) begin
        n_ls++;
        if ((last_ls >= 0) && (i - last_ls != 32)) gap_bad++;
        last_ls = i;
      end
      if (frame_start) begin
        n_fs++;
        if ((pixel_x != 10'd0) || (pixel_y != 10'd0)) fs_bad++;
        if ((last_fs >= 0) && (i - last_fs != 288)) gap_bad++;
        last_fs = i;
      end
      exp_v = (pixel_x < 10'd8) && (pixel_y < 10'd4);
      exp_h = !((pixel_x >= 10'd10) && (pixel_x <= 10'd12));
      exp_s = !((pixel_y >= 10'd5) && (pixel_y <= 10'd6));
      if ((video_on !== exp_v) || (hsync !== exp_h) || (vsync !== exp_s)) dec_bad++;

      if (p_tick1) n_tick1++;
      if (hsync1) n_hs1++;
      if (vsync1) n_vs1++;
      if (video_on1) n_vid1++;
      if (pixel_x1 != px1) n_xchg1++;
      if (line_start1) begin
        n_ls1++;
        if ((last_ls1 >= 0) && (i - last_ls1 != 16)) gap_bad1++;
        last_ls1 = i;
      end
      if (frame_start1) begin
        n_fs1++;
        if ((last_fs1 >= 0) && (i - last_fs1 != 144)) gap_bad1++;
        last_fs1 = i;
      end
      exp_v = (pixel_x1 < 10'd8) && (pixel_y1 < 10'd4);
      exp_h = (pixel_x1 >= 10'd10) && (pixel_x1 <= 10'd12);
      exp_s = (pixel_y1 >= 10'd5) && (pixel_y1 <= 10'd6);
      if ((video_on1 !== exp_v) || (hsync1 !== exp_h) || (vsync1 !== exp_s)) dec_bad1++;

      px = pixel_x; py = pixel_y; px1 = pixel_x1;
    end

    check("run_p_tick_count", 32'(n_tick), 32'd288);
    check("run_line_start_count", 32'(n_ls), 32'd18);
    check("run_frame_start_count", 32'(n_fs), 32'd2);
    check("run_hsync_low_clks", 32'(n_hs), 32'd108);
    check("run_vsync_low_clks", 32'(n_vs), 32'd128);
    check("run_video_on_clks", 32'(n_vid), 32'd128);
    check("run_x_changes", 32'(n_xchg), 32'd288);
    check("run_max_x", 32'(max_x), 32'd15);
    check("run_max_y", 32'(max_y), 32'd8);
    check("run_period_errors", 32'(gap_bad), 32'd0);
    check("run_decode_errors", 32'(dec_bad), 32'd0);
    check("run_wrap_seen", 32'(wrap_seen != 0), 32'd1);
    check("run_wrap_errors", 32'(wrap_bad), 32'd0);
    check("run_frame_start_pos", 32'(fs_bad), 32'd0);

    check("run1_p_tick_count", 32'(n_tick1), 32'd576);
    check("run1_line_start_count", 32'(n_ls1), 32'd36);
    check("run1_frame_start_count", 32'(n_fs1), 32'd4);
    check("run1_hsync_high_clks", 32'(n_hs1), 32'd108);
    check("run1_vsync_high_clks", 32'(n_vs1), 32'd128);
    check("run1_video_on_clks", 32'(n_vid1), 32'd128);
    check("run1_x_changes", 32'(n_xchg1), 32'd576);
    check("run1_period_errors", 32'(gap_bad1), 32'd0);
    check("run1_decode_errors", 32'(dec_bad1), 32'd0);

    // Mid-frame reset while both syncs are asserted (x=11, y=5).
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!found) begin
        @(negedge clk);
        if ((pixel_x == 10'd11) && (pixel_y == 10'd5)) found = 1'b1;
      end
    end
    check("mid_target_reached", 32'(found), 32'd1);
    check("mid_hsync_active", 32'(hsync), 32'd0);
    check("mid_vsync_active", 32'(vsync), 32'd0);
    check("mid_video_off", 32'(video_on), 32'd0);

    reset = 1'b1;
    #1;
    check("mid_p_tick_forced", 32'(p_tick), 32'd0);
    check("mid_p_tick1_forced", 32'(p_tick1), 32'd0);
    repeat (3) @(negedge clk);
    check_reset_state("mid");

    reset = 1'b0;
    @(negedge clk);
    check("mid_rel1_video_on", 32'(video_on), 32'd1);
    check("mid_rel1_frame_start", 32'(frame_start), 32'd1);
    check("mid_rel1_hsync", 32'(hsync), 32'd1);
    @(negedge clk);
    check("mid_rel2_x", 32'(pixel_x), 32'd1);
    check("mid_rel2_frame_start", 32'(frame_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
